// File: rtl/dr_tx_if.sv
// Upstream valid/ready word interface for the dual-rail transmitter.
// The producer drives valid/data; the transmitter returns ready.
interface dr_tx_if #(
    parameter int unsigned WIDTH = 1
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/dr_tx.sv
// Synchronous-to-dual-rail transmitter: one-entry input buffer, two-phase or
// four-phase encoding onto registered rails, paced by a synchronised receiver ack.
module dr_tx #(
    parameter string       ENC         = "TP",
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    dr_tx_if.slave                up,
    output logic [WIDTH-1:0][1:0] out,
    input  logic                  ack_i,
    output logic                  busy
);

    localparam bit IsFp = (ENC == "FP");

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : gen_bad_sync
        $error("dr_tx: SYNC_STAGES must be in 2..4");
    end
    if (ENC != "TP" && ENC != "FP") begin : gen_bad_enc
        $error("dr_tx: ENC must be \"TP\" or \"FP\"");
    end

    typedef enum logic [1:0] {
        StIdle,
        StWaitAck,
        StWaitNack
    } state_e;

    state_e                  state_q, state_d;
    logic [WIDTH-1:0]        buf_q, buf_d;
    logic                    buf_full_q, buf_full_d;
    logic                    ph_q, ph_d;
    logic                    busy_q, busy_d;
    logic [WIDTH-1:0][1:0]   out_q, out_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    ack_s;
    logic                    ready;
    logic                    accept;
    logic                    launch;

    // TP toggles exactly one rail per bit; FP drives the code word from the spacer.
    function automatic logic [WIDTH-1:0][1:0] encode(input logic [WIDTH-1:0][1:0] cur,
                                                     input logic [WIDTH-1:0]      d);
        logic [WIDTH-1:0][1:0] enc;
        for (int b = 0; b < WIDTH; b++) begin
            if (IsFp) begin
                enc[b] = {d[b], ~d[b]};
            end else begin
                enc[b] = cur[b] ^ {d[b], ~d[b]};
            end
        end
        return enc;
    endfunction

    assign ready       = !rst && !buf_full_q;
    assign up.in_ready = ready;
    assign accept      = up.in_valid && ready;
    assign ack_s       = sync_q[SYNC_STAGES-1];
    assign out         = out_q;
    assign busy        = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ack_i};
        end
    end

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        ph_d       = ph_q;
        busy_d     = busy_q;
        out_d      = out_q;
        launch     = 1'b0;

        case (state_q)
            StIdle: begin
                if (buf_full_q) begin
                    launch  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = StWaitAck;
                end
            end
            StWaitAck: begin
                if (IsFp) begin
                    if (ack_s) begin
                        out_d   = '0;
                        state_d = StWaitNack;
                    end
                end else if (ack_s != ph_q) begin
                    ph_d = ~ph_q;
                    // A buffered word goes out on the same edge the phase closes.
                    if (buf_full_q) begin
                        launch = 1'b1;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            StWaitNack: begin
                if (!ack_s) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (launch) begin
            out_d      = encode(out_q, buf_q);
            buf_full_d = 1'b0;
        end
        if (accept) begin
            buf_d      = up.in_data;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            ph_q       <= 1'b0;
            busy_q     <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            ph_q       <= ph_d;
            busy_q     <= busy_d;
            out_q      <= out_d;
        end
    end

endmodule

// File: tb/tb_dr_tx.sv
// Bench for dr_tx: one TP and one FP instance, a dual-rail receiver model with a
// word scoreboard, directed protocol checks and a random integration run.
module tb_dr_tx;

    localparam int unsigned W       = 4;
    localparam int unsigned TP_SYNC = 2;
    localparam int unsigned FP_SYNC = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dr_tx_if #(.WIDTH(W)) tp_if ();
    dr_tx_if #(.WIDTH(W)) fp_if ();

    logic [W-1:0][1:0] tp_out, fp_out;
    logic              tp_busy, fp_busy;
    logic              tp_ack, fp_ack;
    logic              tp_ack_man, fp_ack_man;
    logic              tp_ack_auto, fp_ack_auto;
    logic              auto_ack;

    // Manual and receiver-model ack compose by XOR so switching modes is glitch-free.
    assign tp_ack = tp_ack_man ^ tp_ack_auto;
    assign fp_ack = fp_ack_man ^ fp_ack_auto;

    dr_tx #(.ENC("TP"), .WIDTH(W), .SYNC_STAGES(TP_SYNC)) u_tp (
        .clk   (clk),
        .rst   (rst),
        .up    (tp_if),
        .out   (tp_out),
        .ack_i (tp_ack),
        .busy  (tp_busy)
    );

    dr_tx #(.ENC("FP"), .WIDTH(W), .SYNC_STAGES(FP_SYNC)) u_fp (
        .clk   (clk),
        .rst   (rst),
        .up    (fp_if),
        .out   (fp_out),
        .ack_i (fp_ack),
        .busy  (fp_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Receiver model and scoreboard
    logic [W-1:0]      tp_q[$];
    logic [W-1:0]      fp_q[$];
    logic [W-1:0][1:0] tp_prev, fp_prev;

    always @(negedge clk) begin
        logic [W-1:0][1:0] diff;
        logic [W-1:0]      word;
        logic [W-1:0]      exp_w;
        logic              ok;
        if (rst) begin
            tp_q.delete();
            fp_q.delete();
            tp_prev     = '0;
            fp_prev     = '0;
            tp_ack_auto = 1'b0;
            fp_ack_auto = 1'b0;
        end else begin
            if (tp_if.in_valid && tp_if.in_ready) tp_q.push_back(tp_if.in_data);
            if (fp_if.in_valid && fp_if.in_ready) fp_q.push_back(fp_if.in_data);

            if (tp_out !== tp_prev) begin
                diff = tp_out ^ tp_prev;
                ok   = 1'b1;
                for (int b = 0; b < W; b++) begin
                    ok      = ok && (diff[b] == 2'b01 || diff[b] == 2'b10);
                    word[b] = diff[b][1];
                end
                check_eq("tp_one_rail_per_bit", 32'(ok), 32'd1);
                exp_w = (tp_q.size() > 0) ? tp_q.pop_front() : 'x;
                check_eq("tp_word", 32'(word), 32'(exp_w));
                if (auto_ack) tp_ack_auto = ~tp_ack_auto;
            end
            tp_prev = tp_out;

            if (fp_out !== fp_prev) begin
                if (fp_out == '0) begin
                    if (auto_ack) fp_ack_auto = 1'b0;
                end else begin
                    check_eq("fp_from_spacer", 32'(fp_prev), 32'd0);
                    ok = 1'b1;
                    for (int b = 0; b < W; b++) begin
                        ok      = ok && (fp_out[b] == 2'b01 || fp_out[b] == 2'b10);
                        word[b] = fp_out[b][1];
                    end
                    check_eq("fp_complete_code", 32'(ok), 32'd1);
                    exp_w = (fp_q.size() > 0) ? fp_q.pop_front() : 'x;
                    check_eq("fp_word", 32'(word), 32'(exp_w));
                    if (auto_ack) fp_ack_auto = 1'b1;
                end
            end
            fp_prev = fp_out;
        end
    end

    task automatic send_random(input bit sel, input int n);
        for (int i = 0; i < n; i++) begin
            logic [W-1:0] w;
            bit           acc;
            w   = W'($urandom);
            acc = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            for (int t = 0; t < 400 && !acc; t++) begin
                if (sel) begin
                    fp_if.in_valid = 1'b1;
                    fp_if.in_data  = w;
                    acc            = fp_if.in_ready;
                end else begin
                    tp_if.in_valid = 1'b1;
                    tp_if.in_data  = w;
                    acc            = tp_if.in_ready;
                end
                tick();
            end
            if (sel) fp_if.in_valid = 1'b0;
            else     tp_if.in_valid = 1'b0;
            check_eq(sel ? "fp_accept_in_bound" : "tp_accept_in_bound", 32'(acc), 32'd1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] wlist [3];
        int           idx;
        bit           acc;

        rst            = 1'b1;
        auto_ack       = 1'b0;
        tp_ack_man     = 1'b0;
        fp_ack_man     = 1'b0;
        tp_if.in_valid = 1'b0;
        tp_if.in_data  = '0;
        fp_if.in_valid = 1'b0;
        fp_if.in_data  = '0;
        repeat (3) tick();
        check_eq("rst_tp_out", 32'(tp_out), 32'd0);
        check_eq("rst_tp_busy", 32'(tp_busy), 32'd0);
        check_eq("rst_tp_ready", 32'(tp_if.in_ready), 32'd0);
        check_eq("rst_fp_out", 32'(fp_out), 32'd0);
        check_eq("rst_fp_ready", 32'(fp_if.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("tp_ready_after_reset", 32'(tp_if.in_ready), 32'd1);

        // TP single word
        tp_if.in_valid = 1'b1;
        tp_if.in_data  = 4'b1010;
        tick();
        tp_if.in_valid = 1'b0;
        check_eq("tp_not_before_launch", 32'(tp_out), 32'd0);
        check_eq("tp_ready_buf_full", 32'(tp_if.in_ready), 32'd0);
        tick();
        check_eq("tp_launch_1010", 32'(tp_out), 32'h99);
        check_eq("tp_busy_launch", 32'(tp_busy), 32'd1);
        tp_ack_man = 1'b1;
        repeat (TP_SYNC) tick();
        check_eq("tp_busy_during_sync", 32'(tp_busy), 32'd1);
        tick();
        check_eq("tp_busy_after_ack", 32'(tp_busy), 32'd0);
        check_eq("tp_rails_hold", 32'(tp_out), 32'h99);

        // TP back-to-back
        tp_if.in_valid = 1'b1;
        tp_if.in_data  = 4'hF;
        tick();
        tick();
        check_eq("tp_b2b_first", 32'(tp_out), 32'h33);
        tick();
        tp_if.in_valid = 1'b0;
        check_eq("tp_b2b_held_ready", 32'(tp_if.in_ready), 32'd0);
        repeat (2) tick();
        check_eq("tp_b2b_stable", 32'(tp_out), 32'h33);
        tp_ack_man = 1'b0;
        repeat (TP_SYNC) tick();
        check_eq("tp_b2b_wait_sync", 32'(tp_out), 32'h33);
        tick();
        check_eq("tp_b2b_second", 32'(tp_out), 32'h99);
        check_eq("tp_b2b_busy", 32'(tp_busy), 32'd1);
        check_eq("tp_b2b_ready", 32'(tp_if.in_ready), 32'd1);
        tp_ack_man = 1'b1;
        repeat (TP_SYNC + 1) tick();
        check_eq("tp_b2b_done", 32'(tp_busy), 32'd0);

        // FP single word, then a second word held until return-to-zero completes
        fp_if.in_valid = 1'b1;
        fp_if.in_data  = 4'b0110;
        tick();
        fp_if.in_data = 4'h3;
        tick();
        check_eq("fp_launch_0110", 32'(fp_out), 32'h69);
        check_eq("fp_busy_launch", 32'(fp_busy), 32'd1);
        tick();
        fp_if.in_valid = 1'b0;
        check_eq("fp_second_buffered", 32'(fp_if.in_ready), 32'd0);
        fp_ack_man = 1'b1;
        repeat (FP_SYNC) tick();
        check_eq("fp_hold_until_ack", 32'(fp_out), 32'h69);
        tick();
        check_eq("fp_spacer", 32'(fp_out), 32'd0);
        check_eq("fp_busy_in_nack", 32'(fp_busy), 32'd1);
        fp_ack_man = 1'b0;
        repeat (FP_SYNC) tick();
        check_eq("fp_busy_wait_nack", 32'(fp_busy), 32'd1);
        tick();
        check_eq("fp_idle_busy", 32'(fp_busy), 32'd0);
        check_eq("fp_no_b2b", 32'(fp_out), 32'd0);
        tick();
        check_eq("fp_launch_3", 32'(fp_out), 32'h5A);
        fp_ack_man = 1'b1;
        repeat (FP_SYNC + 1) tick();
        check_eq("fp_spacer_2", 32'(fp_out), 32'd0);
        fp_ack_man = 1'b0;
        repeat (FP_SYNC + 1) tick();
        check_eq("fp_done_2", 32'(fp_busy), 32'd0);

        // Buffer full with no ack: exactly two of three words accepted
        wlist[0] = 4'hC;
        wlist[1] = 4'h5;
        wlist[2] = 4'hA;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            fp_if.in_valid = (idx < 3);
            if (idx < 3) fp_if.in_data = wlist[idx];
            acc = fp_if.in_valid && fp_if.in_ready;
            tick();
            if (acc) idx++;
        end
        fp_if.in_valid = 1'b0;
        check_eq("fp_full_accepted", 32'(idx), 32'd2);
        check_eq("fp_full_ready", 32'(fp_if.in_ready), 32'd0);
        check_eq("fp_full_busy", 32'(fp_busy), 32'd1);

        // Asynchronous reset mid-token
        #3;
        rst        = 1'b1;
        tp_ack_man = 1'b0;
        #1;
        check_eq("rst_mid_out", 32'(fp_out), 32'd0);
        check_eq("rst_mid_busy", 32'(fp_busy), 32'd0);
        check_eq("rst_mid_ready", 32'(fp_if.in_ready), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        fp_if.in_valid = 1'b1;
        fp_if.in_data  = 4'h9;
        tp_if.in_valid = 1'b1;
        tp_if.in_data  = 4'h6;
        tick();
        fp_if.in_valid = 1'b0;
        tp_if.in_valid = 1'b0;
        check_eq("post_rst_latency", 32'(fp_out), 32'd0);
        tick();
        check_eq("post_rst_fp_launch", 32'(fp_out), 32'h96);
        check_eq("post_rst_tp_launch", 32'(tp_out), 32'h69);
        fp_ack_man = 1'b1;
        tp_ack_man = 1'b1;
        repeat (FP_SYNC + 1) tick();
        check_eq("post_rst_tp_done", 32'(tp_busy), 32'd0);
        fp_ack_man = 1'b0;
        repeat (FP_SYNC + 1) tick();
        check_eq("post_rst_fp_done", 32'(fp_busy), 32'd0);

        // Random integration with the receiver model closing every handshake
        auto_ack = 1'b1;
        fork
            send_random(1'b0, 100);
            send_random(1'b1, 100);
        join
        for (int t = 0; t < 500 && (tp_q.size() > 0 || fp_q.size() > 0 || tp_busy || fp_busy);
             t++) begin
            tick();
        end
        repeat (2 * FP_SYNC + 2) tick();
        check_eq("drain_tp_queue", 32'(tp_q.size()), 32'd0);
        check_eq("drain_fp_queue", 32'(fp_q.size()), 32'd0);
        check_eq("drain_tp_busy", 32'(tp_busy), 32'd0);
        check_eq("drain_fp_busy", 32'(fp_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
